// File: rtl/poisson_spike_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poisson_pkg
//  Purpose  : Shared types and constants for the Poisson spike encoder.
//             pg_state_t : scan FSM state encoding
//             c_RATE_W   : default rate / random word width (matches LFSR)
//  Revision : 1.0 - initial release
// ============================================================================
package poisson_pkg;

   localparam int c_RATE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } pg_state_t;

endpackage
`default_nettype wire

// File: rtl/poisson_spike_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : poisson_spike_gen_if
//  Purpose  : Spike event valid/ready channel toward the spike input queue.
//  Signals  : spike_valid - event pending (master -> slave)
//             spike_ready - downstream accepts event (slave -> master)
//             spike_addr  - channel index of the pending event
//  Modports : master (encoder side), slave (queue side)
//  Revision : 1.0 - initial release
// ============================================================================
interface poisson_spike_gen_if #(
   parameter int CH_W = 4
);
   logic            spike_valid;
   logic            spike_ready;
   logic [CH_W-1:0] spike_addr;

   modport master (output spike_valid, output spike_addr, input spike_ready);
   modport slave  (input spike_valid, input spike_addr, output spike_ready);
endinterface
`default_nettype wire

// File: rtl/poisson_spike_gen_rate_mem.sv
`default_nettype none
// ============================================================================
//  Module   : rate_mem
//  Purpose  : Per-channel firing-rate register file. Synchronous write,
//             asynchronous read, synchronous clear on reset.
//  Ports    : clk, reset           - clock / sync active-high reset
//             i_wr_en/addr/rate    - write port
//             i_rd_addr, o_rd_rate - combinational read port
//  Revision : 1.0 - initial release
// ============================================================================
module rate_mem
   import poisson_pkg::*;
#(
   parameter int N_CH   = 16,
   parameter int CH_W   = $clog2(N_CH),
   parameter int RATE_W = c_RATE_W
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              i_wr_en,
   input  wire logic [CH_W-1:0]   i_wr_addr,
   input  wire logic [RATE_W-1:0] i_wr_rate,
   input  wire logic [CH_W-1:0]   i_rd_addr,
   output logic      [RATE_W-1:0] o_rd_rate
);

   logic [RATE_W-1:0] r_mem [N_CH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_rate;
      end
   end

   // Read sees the pre-edge contents, so a write to the channel being
   // evaluated in the same cycle only affects later evaluations.
   assign o_rd_rate = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/poisson_spike_gen.sv
`default_nettype none
// ============================================================================
//  Module   : poisson_spike_gen
//  Purpose  : Stochastic (Poisson) input encoder. On each tick, scans all
//             channels once, comparing one LFSR word per channel against the
//             programmed rate, and emits a spike event for each firing one.
//  Ports    : clk, reset        - clock / sync active-high reset
//             rand_en, rand_in  - LFSR enable out / random word in
//             wr_en/addr/rate   - rate table write port
//             tick              - timestep start pulse
//             busy, done        - scan in progress / scan complete pulse
//             overrun           - pulse when a tick is dropped
//             spike             - event channel (valid/ready/addr), master
//  Revision : 1.0 - initial release
// ============================================================================
module poisson_spike_gen
   import poisson_pkg::*;
#(
   parameter int N_CH   = 16,
   parameter int CH_W   = $clog2(N_CH),
   parameter int RATE_W = c_RATE_W
) (
   input  wire logic              clk,
   input  wire logic              reset,
   output logic                   rand_en,
   input  wire logic [RATE_W-1:0] rand_in,
   input  wire logic              wr_en,
   input  wire logic [CH_W-1:0]   wr_addr,
   input  wire logic [RATE_W-1:0] wr_rate,
   input  wire logic              tick,
   output logic                   busy,
   output logic                   done,
   output logic                   overrun,
   poisson_spike_gen_if.master    spike
);

   localparam logic [CH_W-1:0] c_LAST_CH = CH_W'(N_CH - 1);

   pg_state_t         r_state, w_state_next;
   logic [CH_W-1:0]   r_ch, w_ch_next;
   logic [CH_W-1:0]   r_spike_addr, w_spike_addr_next;
   logic [RATE_W-1:0] w_rate;
   logic              r_overrun;
   logic              r_rand_en;
   logic              w_fire;
   logic              w_last;
   logic              w_hs;

   rate_mem #(
      .N_CH   (N_CH),
      .CH_W   (CH_W),
      .RATE_W (RATE_W)
   ) u_rate_mem (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_rate (wr_rate),
      .i_rd_addr (r_ch),
      .o_rd_rate (w_rate)
   );

   // Strict less-than: rate 0 never fires, all-ones rate misses only the
   // all-ones random word.
   assign w_fire = (rand_in < w_rate);
   assign w_last = (r_ch == c_LAST_CH);
   assign w_hs   = spike.spike_valid & spike.spike_ready;

   always_comb begin
      w_state_next      = r_state;
      w_ch_next         = r_ch;
      w_spike_addr_next = r_spike_addr;
      busy              = 1'b0;
      done              = 1'b0;
      spike.spike_valid = 1'b0;

      case (r_state)
         IDLE: begin
            if (tick) begin
               w_state_next = SCAN;
               w_ch_next    = '0;
            end
         end
         SCAN: begin
            busy = 1'b1;
            if (w_fire) begin
               w_state_next      = EMIT;
               w_spike_addr_next = r_ch;
            end else if (w_last) begin
               w_state_next = DONE;
            end else begin
               w_ch_next = r_ch + 1'b1;
            end
         end
         EMIT: begin
            busy              = 1'b1;
            spike.spike_valid = 1'b1;
            if (w_hs) begin
               if (w_last) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next = SCAN;
                  w_ch_next    = r_ch + 1'b1;
               end
            end
         end
         DONE: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_ch         <= '0;
         r_spike_addr <= '0;
         r_overrun    <= 1'b0;
         r_rand_en    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_ch         <= w_ch_next;
         r_spike_addr <= w_spike_addr_next;
         // Ticks are only accepted in IDLE; anything else is reported.
         r_overrun    <= tick & (r_state != IDLE);
         // LFSR must free-run outside reset; it reseeds when disabled.
         r_rand_en    <= 1'b1;
      end
   end

   assign rand_en          = r_rand_en;
   assign overrun          = r_overrun;
   assign spike.spike_addr = r_spike_addr;

endmodule
`default_nettype wire

// File: tb/tb_poisson_spike_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poisson_spike_gen
//  Purpose  : Directed self-checking bench for poisson_spike_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_poisson_spike_gen;

   localparam int N_CH   = 16;
   localparam int CH_W   = 4;
   localparam int RATE_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              rand_en;
   logic [RATE_W-1:0] rand_in;
   logic              wr_en;
   logic [CH_W-1:0]   wr_addr;
   logic [RATE_W-1:0] wr_rate;
   logic              tick;
   logic              busy;
   logic              done;
   logic              overrun;

   int n_checks = 0;
   int n_errors = 0;

   int q_ev[$];
   int done_at;
   int busy_cnt;
   int busy_at_done;
   int done_cnt;
   int k_done;

   always #5 clk = ~clk;

   poisson_spike_gen_if #(.CH_W(CH_W)) u_if ();

   poisson_spike_gen #(
      .N_CH   (N_CH),
      .CH_W   (CH_W),
      .RATE_W (RATE_W)
   ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .rand_en (rand_en),
      .rand_in (rand_in),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_rate (wr_rate),
      .tick    (tick),
      .busy    (busy),
      .done    (done),
      .overrun (overrun),
      .spike   (u_if)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Each step lands on a falling edge: outputs are sampled and inputs
   // driven for the cycle that ends at the next rising edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic write_rate(input int a, input logic [RATE_W-1:0] r);
      wr_en   = 1'b1;
      wr_addr = CH_W'(a);
      wr_rate = r;
      step();
      wr_en   = 1'b0;
   endtask

   // Issue a tick and monitor the scan; done_at is the cycle offset from
   // the tick cycle at which done is seen (-1 if the budget expires).
   // An optional rate write is driven at offset wr_cyc.
   task automatic do_tick(input int budget, input int wr_cyc, input int wr_a,
                          input logic [RATE_W-1:0] wr_r);
      q_ev.delete();
      done_at      = -1;
      busy_cnt     = 0;
      busy_at_done = -1;
      tick = 1'b1;
      step();
      tick = 1'b0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         if (done) begin
            done_at      = cyc;
            busy_at_done = int'(busy);
            break;
         end
         if (busy) busy_cnt++;
         if (u_if.spike_valid && u_if.spike_ready) q_ev.push_back(int'(u_if.spike_addr));
         if (cyc == wr_cyc) begin
            wr_en   = 1'b1;
            wr_addr = CH_W'(wr_a);
            wr_rate = wr_r;
         end else begin
            wr_en = 1'b0;
         end
         step();
      end
      wr_en = 1'b0;
      step();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      tick             = 1'b0;
      wr_en            = 1'b0;
      wr_addr          = '0;
      wr_rate          = '0;
      rand_in          = 16'h1234;
      u_if.spike_ready = 1'b1;
      step();
      step();
      step();

      // ---- reset values ----
      check("rst_valid",   32'(u_if.spike_valid), 0);
      check("rst_addr",    32'(u_if.spike_addr),  0);
      check("rst_busy",    32'(busy),             0);
      check("rst_done",    32'(done),             0);
      check("rst_overrun", 32'(overrun),          0);
      check("rst_rand_en", 32'(rand_en),          0);
      reset = 1'b0;
      step();
      check("rand_en_up",  32'(rand_en),          1);

      // ---- zero-spike scan ----
      do_tick(40, -1, 0, '0);
      check("t1_done_at",   32'(done_at),      17);
      check("t1_busy_cnt",  32'(busy_cnt),     16);
      check("t1_busy_done", 32'(busy_at_done), 0);
      check("t1_events",    32'(q_ev.size()),  0);
      check("t1_done_drop", 32'(done),         0);

      // ---- all channels fire, ready tied high ----
      for (int i = 0; i < N_CH; i++) write_rate(i, 16'hFFFF);
      rand_in = 16'h1234;
      do_tick(60, -1, 0, '0);
      check("t2_done_at",  32'(done_at),     33);
      check("t2_busy_cnt", 32'(busy_cnt),    32);
      check("t2_events",   32'(q_ev.size()), 16);
      if (q_ev.size() == 16) begin
         for (int i = 0; i < N_CH; i++) check($sformatf("t2_addr%0d", i), 32'(q_ev[i]), 32'(i));
      end

      // ---- single channel, compare boundary ----
      apply_reset();
      write_rate(5, 16'h8000);
      rand_in = 16'h7FFF;
      do_tick(40, -1, 0, '0);
      check("t3a_events",  32'(q_ev.size()), 1);
      if (q_ev.size() == 1) check("t3a_addr", 32'(q_ev[0]), 5);
      check("t3a_done_at", 32'(done_at), 18);
      rand_in = 16'h8000;
      do_tick(40, -1, 0, '0);
      check("t3b_events",  32'(q_ev.size()), 0);
      check("t3b_done_at", 32'(done_at), 17);
      write_rate(5, 16'hFFFF);
      rand_in = 16'hFFFF;
      do_tick(40, -1, 0, '0);
      check("t3c_events",  32'(q_ev.size()), 0);
      rand_in = 16'hFFFE;
      do_tick(40, -1, 0, '0);
      check("t3d_events",  32'(q_ev.size()), 1);
      check("t3d_done_at", 32'(done_at), 18);

      // ---- backpressure stall on channel 3 ----
      apply_reset();
      write_rate(3, 16'hFFFF);
      rand_in          = 16'h1234;
      u_if.spike_ready = 1'b0;
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (4) step();
      for (int k = 0; k < 10; k++) begin
         check($sformatf("t4_valid_s%0d", k), 32'(u_if.spike_valid), 1);
         check($sformatf("t4_addr_s%0d", k),  32'(u_if.spike_addr),  3);
         step();
      end
      u_if.spike_ready = 1'b1;
      check("t4_valid_hs", 32'(u_if.spike_valid), 1);
      step();
      check("t4_valid_after", 32'(u_if.spike_valid), 0);
      check("t4_busy_after",  32'(busy),             1);
      k_done = -1;
      for (int k = 16; k <= 40; k++) begin
         if (done) begin
            k_done = k;
            break;
         end
         step();
      end
      check("t4_done_at", 32'(k_done), 28);
      step();

      // ---- tick during SCAN is dropped ----
      apply_reset();
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("t5_ovr_idle", 32'(overrun), 0);
      step();
      step();
      tick = 1'b1;
      check("t5_ovr_pre", 32'(overrun), 0);
      step();
      tick = 1'b0;
      check("t5_ovr_pulse", 32'(overrun), 1);
      step();
      check("t5_ovr_clear", 32'(overrun), 0);
      k_done = -1;
      for (int k = 5; k <= 40; k++) begin
         if (done) begin
            k_done = k;
            break;
         end
         step();
      end
      check("t5_done_at", 32'(k_done), 17);
      step();

      // ---- reset while an event is pending ----
      apply_reset();
      write_rate(3, 16'hFFFF);
      rand_in          = 16'h1234;
      u_if.spike_ready = 1'b0;
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (4) step();
      check("t6_valid_pre", 32'(u_if.spike_valid), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      u_if.spike_ready = 1'b1;
      check("t6_valid_rst", 32'(u_if.spike_valid), 0);
      check("t6_busy_rst",  32'(busy),             0);
      check("t6_addr_rst",  32'(u_if.spike_addr),  0);
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) done_cnt++;
         step();
      end
      check("t6_no_done", 32'(done_cnt), 0);
      do_tick(40, -1, 0, '0);
      check("t6_cleared_events", 32'(q_ev.size()), 0);
      check("t6_done_at",        32'(done_at),     17);

      // ---- write to channel under evaluation ----
      apply_reset();
      rand_in = 16'h1234;
      do_tick(40, 3, 2, 16'hFFFF);
      check("t7a_events",  32'(q_ev.size()), 0);
      check("t7a_done_at", 32'(done_at),     17);
      do_tick(40, -1, 0, '0);
      check("t7b_events",  32'(q_ev.size()), 1);
      if (q_ev.size() == 1) check("t7b_addr", 32'(q_ev[0]), 2);
      check("t7b_done_at", 32'(done_at), 18);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/poisson_spike_gen.md
# poisson_spike_gen

Stochastic input encoder for the neuromorphic core: on each timestep `tick` it scans `N_CH` input channels once. For each channel it compares one 16-bit pseudo-random word from the shared LFSR against that channel's programmed firing rate. Every channel whose comparison fires is emitted as a spike event, carrying the channel index, over a valid/ready handshake toward the synapse/neuron update logic. It sits between the LFSR (source of `rand_in`) and the spike input queue.

## Interface
- `N_CH`, 16, number of input channels (power of two, ≥2)
- `CH_W`, `$clog2(N_CH)`, channel index width
- `RATE_W`, 16, rate and random word width; must equal the LFSR length
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `rand_en`  out  1  enable to the LFSR
- `rand_in`  in  RATE_W  current LFSR output word
- `wr_en`  in  1  rate table write strobe
- `wr_addr`  in  CH_W  rate table write index
- `wr_rate`  in  RATE_W  rate value; spike probability ≈ wr_rate/2^RATE_W
- `tick`  in  1  timestep start pulse
- `busy`  out  1  scan in progress (SCAN or EMIT)
- `spike_valid`  out  1  spike event pending
- `spike_ready`  in  1  downstream accepts event
- `spike_addr`  out  CH_W  channel index of the pending event
- `done`  out  1  one-cycle pulse when the timestep scan completes
- `overrun`  out  1  one-cycle pulse when a `tick` is dropped

## Operation
- Rate table: `N_CH` × `RATE_W` registers, all cleared to 0 by `reset`. A write with `wr_en`=1 takes effect on the next edge. Writes are allowed in any state.
- Same-cycle write to the channel under evaluation: the compare uses the old value.
- `rand_en` = `~reset`, registered. The LFSR reloads its seed whenever its enable is low, so `rand_en` must stay high continuously outside reset. The sequence therefore free-runs across timesteps. `rand_in` is never 0.
- Fire rule: spike iff `rand_in < rate[ch]`, unsigned compare using `rand_in` in the evaluation cycle.
  - Rate 0 never fires.
  - Rate 2^RATE_W−1 fires unless `rand_in` is all-ones.
- FSM states:
  - IDLE: on `tick` → SCAN with `ch`=0.
  - SCAN: evaluate `ch`. If it fires → EMIT with `spike_addr`=`ch`. If it does not fire: → DONE when `ch`=N_CH−1, otherwise `ch`++ and stay in SCAN.
  - EMIT: hold `spike_valid`=1 and `spike_addr` stable until `spike_valid & spike_ready`. Then → DONE if `ch`=N_CH−1, else `ch`++ → SCAN.
  - DONE: `done`=1 for one cycle, then → IDLE.
- `tick` is accepted only in IDLE. A `tick` in SCAN, EMIT or DONE is dropped and pulses `overrun` on the next cycle.
- Random words consumed while stalled in EMIT are discarded; no buffering.
- `ch` counter width is CH_W. It never wraps inside a scan, and the last-channel test is `ch == N_CH−1`.

## Timing
- Reset values: `spike_valid`=0, `spike_addr`=0, `busy`=0, `done`=0, `overrun`=0, `rand_en`=0. State is IDLE, `ch`=0, rates are 0. `rand_en` goes to 1 one cycle after `reset` deasserts.
- `tick` at cycle t → SCAN evaluates ch0 at t+1; `busy`=1 from t+1.
- A non-firing channel costs 1 cycle.
- Firing channel evaluated at cycle c → `spike_valid`=1 from c+1. Handshake at cycle h → next channel evaluated at h+1, and `spike_valid`=0 at h+1.
- With `spike_ready` tied high, each firing channel costs 2 cycles.
- Zero-spike scan: `tick`@t → SCAN t+1..t+N_CH, `done`=1 at t+N_CH+1, `busy`=0 at t+N_CH+1, IDLE at t+N_CH+2.
- Next accepted `tick` is the earliest at t+N_CH+2 (zero-spike case).
- `reset` mid-scan: next cycle is IDLE with all outputs at reset values. The pending event is lost and no `done` is produced.
- `spike_valid` never drops without a handshake except by `reset`.

## Structure
- Package `poisson_pkg`: state enum `pg_state_t` {IDLE, SCAN, EMIT, DONE} and the default `RATE_W` constant (16).
- Sub-module `rate_mem`: register-file rate table with synchronous write, asynchronous read by `ch`, and synchronous clear on `reset`.
- FSM, channel counter and comparator stay in the top level.

## Test plan
- All rates 0, `tick` → no `spike_valid` for 16 cycles; `done` pulses at t+17; `busy` high t+1..t+16.
- All rates 0xFFFF, `spike_ready`=1, `rand_in` driven 0x1234 → 16 events, addr 0..15 in order; `done` at t+33.
- rate[5]=0x8000, others 0, `rand_in`=0x7FFF during ch5's evaluation → single event addr 5. Repeat with 0x8000 → no event.
- Single event with `spike_ready` held low 10 cycles → `spike_valid` and `spike_addr`=3 stable for the whole stall; scan resumes at ch4 the cycle after the handshake.
- `tick` during SCAN → `overrun` pulses once and the scan completes unchanged. `reset` asserted mid-EMIT → `spike_valid`=0 the next cycle, no `done`, rates cleared.
- Write to rate[2] in the same cycle ch2 is evaluated → old rate governs. The following timestep uses the new rate.
